// File: rtl/dcache_ecc_scrubber.sv
// Background ECC scrubber on the lowest-priority tag_cmp requester port; fixes single-bit errors in place.
// Latency: one set visit per INTERVAL cycles (NEXT counts as the first cycle); RD->CHK is one cycle after grant.
// Backpressure: RD holds req/addr until gnt_i; an ungranted CHK write is dropped and the set is re-read.
// Ports: clk_i/rst_i (sync, active-high); enable_i/clear_i control; req_o/gnt_i/addr_o/we_o/be_o/wdata_o
//   drive the tag_cmp port; rdata_i/rvalid_i/err_i are the decoded read results (valid in CHK only);
//   busy_o, sweep_done_o, corr_cnt_o, uncorr_cnt_o, uncorr_o report status.
module dcache_ecc_scrubber #(
  parameter int DCACHE_SET_ASSOC = 8,
  parameter int NUM_SETS         = 256,
  parameter int LINE_WIDTH       = 128,
  parameter int OFFSET_WIDTH     = 4,
  parameter int ADDR_WIDTH       = 64,
  parameter int INTERVAL         = 1024
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   enable_i,
  input  logic                                   clear_i,
  output logic [DCACHE_SET_ASSOC-1:0]            req_o,
  input  logic                                   gnt_i,
  output logic [ADDR_WIDTH-1:0]                  addr_o,
  output logic                                   we_o,
  output logic [LINE_WIDTH/8-1:0]                be_o,
  output logic [LINE_WIDTH-1:0]                  wdata_o,
  input  logic [DCACHE_SET_ASSOC*LINE_WIDTH-1:0] rdata_i,
  input  logic [DCACHE_SET_ASSOC-1:0]            rvalid_i,
  input  logic [DCACHE_SET_ASSOC*2-1:0]          err_i,
  output logic                                   busy_o,
  output logic                                   sweep_done_o,
  output logic [15:0]                            corr_cnt_o,
  output logic [15:0]                            uncorr_cnt_o,
  output logic                                   uncorr_o
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = $clog2(INTERVAL + 1);
  localparam int PW = $clog2(DCACHE_SET_ASSOC + 1);
  localparam int BW = LINE_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CHK, S_NEXT} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   index_q, index_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     corr_cnt_q, corr_cnt_d;
  logic [15:0]     uncorr_cnt_q, uncorr_cnt_d;
  logic            uncorr_q, uncorr_d;
  logic            first_q, first_d;

  logic [DCACHE_SET_ASSOC-1:0] unc_ways, cor_ways, cor_low;
  logic [PW-1:0]               unc_pop;
  logic [LINE_WIDTH-1:0]       sel_data;
  logic [16:0]                 unc_sum;
  logic [ADDR_WIDTH-1:0]       set_addr;

  assign set_addr = ADDR_WIDTH'({index_q, {OFFSET_WIDTH{1'b0}}});

  // Classify ways from the decoder flags; invalid lines never count.
  always_comb begin
    unc_ways = '0;
    cor_ways = '0;
    unc_pop  = '0;
    for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
      unc_ways[w] = rvalid_i[w] & err_i[2*w+1];
      cor_ways[w] = rvalid_i[w] & (err_i[2*w +: 2] == 2'b01);
      unc_pop     = unc_pop + PW'(unc_ways[w]);
    end
  end

  // Isolate the lowest correctable way and pick its decoded data.
  assign cor_low = cor_ways & (~cor_ways + 1'b1);

  always_comb begin
    sel_data = '0;
    for (int w = 0; w < DCACHE_SET_ASSOC; w++) begin
      if (cor_low[w]) sel_data = rdata_i[w*LINE_WIDTH +: LINE_WIDTH];
    end
  end

  assign unc_sum = {1'b0, uncorr_cnt_q} + 17'(unc_pop);

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    timer_d      = timer_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    uncorr_d     = uncorr_q;
    first_d      = first_q;
    req_o        = '0;
    addr_o       = '0;
    we_o         = 1'b0;
    be_o         = '0;
    wdata_o      = '0;
    sweep_done_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        first_d = 1'b1;
        if (enable_i) begin
          if (timer_q == TW'(INTERVAL - 1)) begin
            timer_d = '0;
            state_d = S_RD;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_RD: begin
        req_o  = '1;
        addr_o = set_addr;
        if (gnt_i) state_d = S_CHK;
      end
      S_CHK: begin
        first_d = 1'b0;
        // A re-read of the same set must not count its uncorrectables twice.
        if (first_q && (unc_pop != '0)) begin
          uncorr_cnt_d = unc_sum[16] ? 16'hFFFF : unc_sum[15:0];
          uncorr_d     = 1'b1;
        end
        if (cor_ways == '0) begin
          state_d = S_NEXT;
        end else begin
          req_o   = cor_low;
          addr_o  = set_addr;
          we_o    = 1'b1;
          be_o    = {BW{1'b1}};
          wdata_o = sel_data;
          if (gnt_i) begin
            if (corr_cnt_q != 16'hFFFF) corr_cnt_d = corr_cnt_q + 16'd1;
            state_d = ((cor_ways & ~cor_low) != '0) ? S_RD : S_NEXT;
          end else begin
            // Data is not held, so a lost write simply re-reads the set.
            state_d = S_RD;
          end
        end
      end
      S_NEXT: begin
        index_d      = index_q + 1'b1;
        sweep_done_o = (index_q == {IW{1'b1}});
        // This cycle is the first cycle of the next interval.
        timer_d      = (INTERVAL > 1) ? TW'(1) : '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_i) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
      uncorr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      timer_q      <= '0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
      uncorr_q     <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      timer_q      <= timer_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      uncorr_q     <= uncorr_d;
      first_q      <= first_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign corr_cnt_o   = corr_cnt_q;
  assign uncorr_cnt_o = uncorr_cnt_q;
  assign uncorr_o     = uncorr_q;

endmodule
